// File: rtl/tube_display_writer.sv
// Eight-digit seven-segment tube driver for the CPU IO space: holds two digit
// halfwords plus a control word and scans one digit per SCAN_DIV clocks.
module tube_display_writer #(
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  logic        tubeclk,
    input  logic        switchrst,
    input  logic        tubectl,
    input  logic        tubewrite,
    input  logic [1:0]  tubeaddr,
    input  logic [15:0] tubewdata,
    output logic [7:0]  tube_en,
    output logic [7:0]  tube_seg
);

    logic [15:0]      val_lo_q;
    logic [15:0]      val_hi_q;
    logic [15:0]      ctrl_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;
    logic [7:0]       tube_en_q;
    logic [7:0]       tube_seg_q;

    logic [31:0] digits;
    logic [7:0]  en_mask;
    logic [7:0]  dp_mask;
    logic [3:0]  nib;
    logic [6:0]  hex_seg;
    logic [7:0]  tube_en_d;
    logic [7:0]  tube_seg_d;

    assign digits  = {val_hi_q, val_lo_q};
    assign en_mask = ctrl_q[7:0];
    assign dp_mask = ctrl_q[15:8];
    assign nib     = digits[{idx_q, 2'b00} +: 4];

    // gfedcba, active-high
    always_comb begin
        hex_seg = 7'h00;
        case (nib)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            4'hF: hex_seg = 7'h71;
            default: hex_seg = 7'h00;
        endcase
    end

    // A disabled digit is fully dark, decimal point included.
    always_comb begin
        tube_en_d  = 8'hFF;
        tube_seg_d = 8'hFF;
        if (en_mask[idx_q]) begin
            tube_en_d  = ~(8'h01 << idx_q);
            tube_seg_d = ~{dp_mask[idx_q], hex_seg};
        end
    end

    always_ff @(negedge tubeclk or posedge switchrst) begin
        if (switchrst) begin
            val_lo_q   <= 16'h0000;
            val_hi_q   <= 16'h0000;
            ctrl_q     <= 16'h00FF;
            div_q      <= '0;
            idx_q      <= 3'd0;
            tube_en_q  <= 8'hFF;
            tube_seg_q <= 8'hFF;
        end else begin
            if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                div_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            if (tubectl && tubewrite) begin
                case (tubeaddr)
                    2'b00:   val_lo_q <= tubewdata;
                    2'b10:   val_hi_q <= tubewdata;
                    2'b01:   ctrl_q   <= tubewdata;
                    default: ;
                endcase
            end

            tube_en_q  <= tube_en_d;
            tube_seg_q <= tube_seg_d;
        end
    end

    assign tube_en  = tube_en_q;
    assign tube_seg = tube_seg_q;

endmodule

// File: tb/tb_tube_display_writer.sv
// Bench for tube_display_writer: directed and random stores compared every cycle
// against an edge-counting model of the scan, plus literal spot checks.
module tb_tube_display_writer;

    localparam int SCAN = 4;

    logic        tubeclk = 1'b0;
    logic        switchrst;
    logic        tubectl   = 1'b0;
    logic        tubewrite = 1'b0;
    logic [1:0]  tubeaddr  = 2'b00;
    logic [15:0] tubewdata = 16'h0000;
    logic [7:0]  tube_en;
    logic [7:0]  tube_seg;

    int checks = 0;
    int errors = 0;

    tube_display_writer #(.SCAN_DIV(SCAN), .DIV_W(3)) dut (
        .tubeclk   (tubeclk),
        .switchrst (switchrst),
        .tubectl   (tubectl),
        .tubewrite (tubewrite),
        .tubeaddr  (tubeaddr),
        .tubewdata (tubewdata),
        .tube_en   (tube_en),
        .tube_seg  (tube_seg)
    );

    always #5 tubeclk = ~tubeclk;

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: the digit shown after the k-th edge since reset is ((k-1)/SCAN) mod 8,
    // drawn from register contents as they stood before that edge.
    logic [15:0] m_lo   = 16'h0000;
    logic [15:0] m_hi   = 16'h0000;
    logic [15:0] m_ctrl = 16'h00FF;
    int          edges  = 0;
    logic [7:0]  exp_en  = 8'hFF;
    logic [7:0]  exp_seg = 8'hFF;
    bit          model_valid = 1'b0;

    always @(negedge tubeclk or posedge switchrst) begin
        if (switchrst) begin
            m_lo = 16'h0000; m_hi = 16'h0000; m_ctrl = 16'h00FF;
            edges = 0; exp_en = 8'hFF; exp_seg = 8'hFF;
        end else begin
            int d;
            logic [31:0] all;
            logic [3:0]  n;
            d   = (edges / SCAN) % 8;
            all = {m_hi, m_lo};
            n   = 4'((all >> (4 * d)) & 32'hF);
            if (m_ctrl[d]) begin
                exp_en  = ~(8'h01 << d);
                exp_seg = ~{m_ctrl[8 + d], HEX[n]};
            end else begin
                exp_en  = 8'hFF;
                exp_seg = 8'hFF;
            end
            if (tubectl && tubewrite) begin
                if (tubeaddr == 2'd0) m_lo = tubewdata;
                else if (tubeaddr == 2'd2) m_hi = tubewdata;
                else if (tubeaddr == 2'd1) m_ctrl = tubewdata;
            end
            edges++;
        end
        model_valid = 1'b1;
    end

    always @(posedge tubeclk) begin
        if (model_valid) begin
            checks++;
            if (tube_en !== exp_en || tube_seg !== exp_seg) begin
                errors++;
                $display("FAIL scan t=%0t: got en=%h seg=%h, expected en=%h seg=%h",
                         $time, tube_en, tube_seg, exp_en, exp_seg);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic store(input logic [1:0] a, input logic [15:0] d,
                         input logic ctl = 1'b1, input logic we = 1'b1);
        @(posedge tubeclk);
        tubectl = ctl; tubewrite = we; tubeaddr = a; tubewdata = d;
        @(posedge tubeclk);
        tubectl = 1'b0; tubewrite = 1'b0;
        $display("store addr=%0d data=%h ctl=%0b we=%0b", a, d, ctl, we);
    endtask

    task automatic wait_digit(input int d);
        logic [7:0] target;
        bit found;
        target = ~(8'h01 << d);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge tubeclk);
            if (tube_en === target) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_digit%0d: got en=%h, expected %h", d, tube_en, target);
        end
    endtask

    logic [7:0] seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    initial begin
        int lit;
        switchrst = 1'b1;
        repeat (3) @(posedge tubeclk);
        chk("reset_en", tube_en, 8'hFF);
        chk("reset_seg", tube_seg, 8'hFF);
        switchrst = 1'b0;
        @(negedge tubeclk); #1;
        chk("first_en", tube_en, 8'hFE);
        chk("first_seg", tube_seg, 8'hC0);
        repeat (40) @(posedge tubeclk);

        store(2'b00, 16'h3210);
        store(2'b10, 16'h7654);
        repeat (2) @(posedge tubeclk);
        for (int d = 0; d < 8; d++) begin
            wait_digit(d);
            chk($sformatf("digit%0d_seg", d), tube_seg, seg_tab[d]);
        end

        store(2'b01, 16'h00F0);
        repeat (40) @(posedge tubeclk);
        wait_digit(4);
        chk("mask_digit4_seg", tube_seg, 8'h99);

        store(2'b00, 16'h000A);
        store(2'b01, 16'h0101);
        repeat (2) @(posedge tubeclk);
        wait_digit(0);
        chk("dp_A_seg", tube_seg, 8'h08);
        lit = 0;
        for (int i = 0; i < 32; i++) begin
            @(posedge tubeclk);
            if (tube_en !== 8'hFF) lit++;
        end
        chk("dp_lit_cycles", 8'(lit), 8'd4);

        store(2'b01, 16'h00FF);
        store(2'b00, 16'hFFFF, 1'b0, 1'b1);
        store(2'b00, 16'hFFFF, 1'b1, 1'b0);
        store(2'b11, 16'hFFFF);
        repeat (2) @(posedge tubeclk);
        wait_digit(0);
        chk("ignored_store_seg", tube_seg, 8'h88);

        for (int i = 0; i < 300; i++) begin
            @(posedge tubeclk);
            tubectl   = 1'($urandom_range(0, 1));
            tubewrite = 1'($urandom_range(0, 1));
            tubeaddr  = 2'($urandom_range(0, 3));
            tubewdata = 16'($urandom);
        end
        @(posedge tubeclk);
        tubectl = 1'b0; tubewrite = 1'b0;

        store(2'b00, 16'h3210);
        store(2'b10, 16'h7654);
        store(2'b01, 16'h00FF);
        repeat (2) @(posedge tubeclk);
        wait_digit(5);
        #3 switchrst = 1'b1;
        #1;
        chk("async_rst_en", tube_en, 8'hFF);
        chk("async_rst_seg", tube_seg, 8'hFF);
        repeat (2) @(posedge tubeclk);
        switchrst = 1'b0;
        @(negedge tubeclk); #1;
        chk("restart_en", tube_en, 8'hFE);
        chk("restart_seg", tube_seg, 8'hC0);
        repeat (40) @(posedge tubeclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
